// File: rtl/rename_map_table_pkg.sv
// Shared rename types (package rename_pkg): areg/preg widths and the renamed-uop record
// consumed by the free list and the ROB.
package rename_pkg;

  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned NUM_AREGS  = 32;
  localparam int unsigned PREG_WIDTH = 6;

  typedef logic [AREG_WIDTH-1:0] areg_t;
  typedef logic [PREG_WIDTH-1:0] preg_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic  is_branch;
  } renamed_uop_t;

  // x0 is hardwired to p0 and never receives a new physical register.
  function automatic logic needs_rename(input logic rd_we, input areg_t rd);
    return rd_we && (rd != '0);
  endfunction

endpackage

// File: rtl/rename_map_table_pipe_reg.sv
// One-entry valid/ready output register with flush; the data is held while stalled.
module rename_pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// Register rename map with a single branch checkpoint and a one-entry output register.
// Optional RENAME_PERF_CNT_EN adds saturating free-list / checkpoint stall counters.
module rename_map_table
  import rename_pkg::*;
#(
  parameter int unsigned PREG_WIDTH = rename_pkg::PREG_WIDTH,
  parameter int unsigned NUM_AREGS  = rename_pkg::NUM_AREGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [4:0]            in_rd,
  input  logic                  in_rd_we,
  input  logic                  in_is_branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PREG_WIDTH-1:0] out_prs1,
  output logic [PREG_WIDTH-1:0] out_prs2,
  output logic [PREG_WIDTH-1:0] out_prd,
  output logic [PREG_WIDTH-1:0] out_old_prd,
  output logic                  out_is_branch,
  output logic                  alloc_req,
  input  logic [PREG_WIDTH-1:0] alloc_preg,
  input  logic                  alloc_valid,
  output logic                  is_branch_dispatch,
  input  logic                  branch_mispredict,
  input  logic                  branch_resolve
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_freelist,
  output logic [31:0]           perf_stall_ckpt
`endif
);

  localparam int unsigned UOP_W = 4 * PREG_WIDTH + 1;

  logic [PREG_WIDTH-1:0] map      [NUM_AREGS];
  logic [PREG_WIDTH-1:0] map_next [NUM_AREGS];
  logic [PREG_WIDTH-1:0] ckpt_map [NUM_AREGS];
  logic                  ckpt_busy;

  logic                  needs_rd;
  logic                  can_out;
  logic                  accept;
  logic [PREG_WIDTH-1:0] new_prd;
  logic [PREG_WIDTH-1:0] old_prd;
  logic [UOP_W-1:0]      uop_in;
  logic [UOP_W-1:0]      uop_out;

  assign needs_rd = needs_rename(in_rd_we, in_rd);
  assign can_out  = !out_valid || out_ready;

  assign in_ready = !reset && !branch_mispredict && can_out
                 && (!needs_rd || alloc_valid)
                 && !(in_is_branch && ckpt_busy);

  assign accept             = in_valid && in_ready;
  assign alloc_req          = accept && needs_rd;
  assign is_branch_dispatch = accept && in_is_branch;

  assign new_prd = needs_rd ? alloc_preg  : '0;
  assign old_prd = needs_rd ? map[in_rd]  : '0;
  assign uop_in  = {map[in_rs1], map[in_rs2], new_prd, old_prd, in_is_branch};

  // The checkpoint captures the map including the branch's own rd write,
  // keeping it aligned with the free list's head+1 shadow pointer.
  always_comb begin
    map_next = map;
    if (alloc_req) begin
      map_next[in_rd] = alloc_preg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++) begin
        map[i]      <= PREG_WIDTH'(i);
        ckpt_map[i] <= PREG_WIDTH'(i);
      end
      ckpt_busy <= 1'b0;
    end else if (branch_mispredict) begin
      map       <= ckpt_map;
      ckpt_busy <= 1'b0;
    end else begin
      map <= map_next;
      if (is_branch_dispatch) begin
        ckpt_map  <= map_next;
        ckpt_busy <= 1'b1;
      end else if (branch_resolve) begin
        ckpt_busy <= 1'b0;
      end
    end
  end

  rename_pipe_reg #(
    .W (UOP_W)
  ) u_pipe_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (branch_mispredict),
    .load      (accept),
    .in_data   (uop_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (uop_out)
  );

  assign {out_prs1, out_prs2, out_prd, out_old_prd, out_is_branch} = uop_out;

  mispredict_needs_ckpt : assert property (
    @(posedge clk) disable iff (reset) branch_mispredict |-> ckpt_busy
  ) else $error("rename_map_table: branch_mispredict with no checkpoint held");

`ifdef RENAME_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_freelist <= '0;
      perf_stall_ckpt     <= '0;
    end else begin
      if (in_valid && needs_rd && !alloc_valid && can_out && perf_stall_freelist != '1) begin
        perf_stall_freelist <= perf_stall_freelist + 32'd1;
      end
      if (in_valid && in_is_branch && ckpt_busy && perf_stall_ckpt != '1) begin
        perf_stall_ckpt <= perf_stall_ckpt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Directed self-checking bench for rename_map_table with hand-computed expectations.
module tb_rename_map_table;

  localparam int unsigned PW = 6;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [4:0]    in_rd;
  logic          in_rd_we;
  logic          in_is_branch;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prs1;
  logic [PW-1:0] out_prs2;
  logic [PW-1:0] out_prd;
  logic [PW-1:0] out_old_prd;
  logic          out_is_branch;
  logic          alloc_req;
  logic [PW-1:0] alloc_preg;
  logic          alloc_valid;
  logic          is_branch_dispatch;
  logic          branch_mispredict;
  logic          branch_resolve;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0]   perf_stall_freelist;
  logic [31:0]   perf_stall_ckpt;
`endif

  int checks = 0;
  int errors = 0;

  rename_map_table #(
    .PREG_WIDTH (PW),
    .NUM_AREGS  (32)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_rs1             (in_rs1),
    .in_rs2             (in_rs2),
    .in_rd              (in_rd),
    .in_rd_we           (in_rd_we),
    .in_is_branch       (in_is_branch),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_prs1           (out_prs1),
    .out_prs2           (out_prs2),
    .out_prd            (out_prd),
    .out_old_prd        (out_old_prd),
    .out_is_branch      (out_is_branch),
    .alloc_req          (alloc_req),
    .alloc_preg         (alloc_preg),
    .alloc_valid        (alloc_valid),
    .is_branch_dispatch (is_branch_dispatch),
    .branch_mispredict  (branch_mispredict),
    .branch_resolve     (branch_resolve)
`ifdef RENAME_PERF_CNT_EN
    ,
    .perf_stall_freelist (perf_stall_freelist),
    .perf_stall_ckpt     (perf_stall_ckpt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic br,
                       input logic [PW-1:0] ap, input logic av);
    in_valid     = v;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_rd_we     = we;
    in_is_branch = br;
    alloc_preg   = ap;
    alloc_valid  = av;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                           input logic [PW-1:0] pd, input logic [PW-1:0] po);
    check({tag, ".valid"},   32'(out_valid),   32'd1);
    check({tag, ".prs1"},    32'(out_prs1),    32'(p1));
    check({tag, ".prs2"},    32'(out_prs2),    32'(p2));
    check({tag, ".prd"},     32'(out_prd),     32'(pd));
    check({tag, ".old_prd"}, 32'(out_old_prd), 32'(po));
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    branch_mispredict = 1'b0;
    branch_resolve = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 6'd32, 1'b1);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.alloc_req", 32'(alloc_req), 32'd0);
    check("rst.br_dispatch", 32'(is_branch_dispatch), 32'd0);
    tick();
    tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_prd", 32'(out_prd), 32'd0);
    check("rst.out_prs1", 32'(out_prs1), 32'd0);
    reset = 1'b0;

    // add x5,x1,x2 <- p32
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 6'd32, 1'b1);
    check("i1.in_ready", 32'(in_ready), 32'd1);
    check("i1.alloc_req", 32'(alloc_req), 32'd1);
    tick();
    check_out("i1", 6'd1, 6'd2, 6'd32, 6'd5);

    // dependent back-to-back: x6 <= x5,x5 <- p33
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 6'd33, 1'b1);
    check("i2.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("i2", 6'd32, 6'd32, 6'd33, 6'd6);

    // reads own rd: x7 <= x7 <- p34 sees old mapping 7
    drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 6'd34, 1'b1);
    tick();
    check_out("i3", 6'd7, 6'd0, 6'd34, 6'd7);

    // rd=x0 with we: no rename, passes even with empty free list
    drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 6'd50, 1'b0);
    check("x0.in_ready", 32'(in_ready), 32'd1);
    check("x0.alloc_req", 32'(alloc_req), 32'd0);
    tick();
    check_out("x0", 6'd33, 6'd0, 6'd0, 6'd0);

    // free list empty: rd instruction stalls
    drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 6'd50, 1'b0);
    check("fl.in_ready", 32'(in_ready), 32'd0);
    check("fl.alloc_req", 32'(alloc_req), 32'd0);
    tick();
    check("fl.out_valid", 32'(out_valid), 32'd0);
`ifdef RENAME_PERF_CNT_EN
    check("fl.perf", perf_stall_freelist, 32'd1);
`endif
    drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 6'd40, 1'b1);
    check("fl2.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("fl2", 6'd1, 6'd2, 6'd40, 6'd8);

    // branch without rd takes checkpoint (x5->32, x8->40)
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 6'd50, 1'b1);
    check("b1.dispatch", 32'(is_branch_dispatch), 32'd1);
    check("b1.alloc_req", 32'(alloc_req), 32'd0);
    tick();
    check_out("b1", 6'd32, 6'd0, 6'd0, 6'd0);
    check("b1.is_branch", 32'(out_is_branch), 32'd1);

    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 6'd41, 1'b1);
    tick();
    check_out("i7", 6'd32, 6'd0, 6'd41, 6'd32);

    // second branch blocked while checkpoint held
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd50, 1'b1);
    check("b2.in_ready", 32'(in_ready), 32'd0);
    check("b2.dispatch", 32'(is_branch_dispatch), 32'd0);
    tick();
    check("b2.out_valid", 32'(out_valid), 32'd0);

    // valid output pending when mispredict hits: it must be flushed
    drive(1'b1, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 6'd51, 1'b1);
    tick();
    check("pre_mp.out_valid", 32'(out_valid), 32'd1);
    branch_mispredict = 1'b1;
    drive(1'b1, 5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 6'd50, 1'b1);
    check("mp1.in_ready", 32'(in_ready), 32'd0);
    check("mp1.alloc_req", 32'(alloc_req), 32'd0);
    tick();
    branch_mispredict = 1'b0;
    check("mp1.out_valid", 32'(out_valid), 32'd0);

    drive(1'b1, 5'd5, 5'd8, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    check_out("mp1.read", 6'd32, 6'd40, 6'd0, 6'd0);
    drive(1'b1, 5'd12, 5'd11, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    check_out("mp1.read2", 6'd12, 6'd11, 6'd0, 6'd0);

    // branch with rd: checkpoint includes its own rd write
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 6'd42, 1'b1);
    check("b3.in_ready", 32'(in_ready), 32'd1);
    check("b3.dispatch", 32'(is_branch_dispatch), 32'd1);
    check("b3.alloc_req", 32'(alloc_req), 32'd1);
    tick();
    check_out("b3", 6'd0, 6'd0, 6'd42, 6'd9);
    drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 6'd43, 1'b1);
    tick();
    check_out("i9", 6'd42, 6'd0, 6'd43, 6'd42);
    branch_mispredict = 1'b1;
    branch_resolve = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    branch_mispredict = 1'b0;
    branch_resolve = 1'b0;
    check("mp2.out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 5'd9, 5'd5, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    check_out("mp2.read", 6'd42, 6'd32, 6'd0, 6'd0);

    // resolve coinciding with a branch accept: new checkpoint wins
    branch_resolve = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd50, 1'b1);
    check("rb.in_ready", 32'(in_ready), 32'd1);
    check("rb.dispatch", 32'(is_branch_dispatch), 32'd1);
    tick();
    branch_resolve = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd50, 1'b1);
    check("rb.busy_stays", 32'(in_ready), 32'd0);
    tick();
    branch_resolve = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    branch_resolve = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd50, 1'b1);
    check("rs.in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // backpressure: output holds, no accept, no alloc
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 6'd45, 1'b1);
    check("bp0.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("bp0", 6'd1, 6'd0, 6'd45, 6'd10);
    drive(1'b1, 5'd10, 5'd0, 5'd10, 1'b1, 1'b0, 6'd46, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.alloc_req", 32'(alloc_req), 32'd0);
      tick();
      check_out("bp.hold", 6'd1, 6'd0, 6'd45, 6'd10);
    end
    out_ready = 1'b1;
    #1;
    check("bp1.in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("bp1", 6'd45, 6'd0, 6'd46, 6'd45);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'd50, 1'b1);
    tick();
    check("end.out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
